// File: rtl/wavetable_reader_pkg.sv
// Shared organ-synth constants: sample period, table geometry, mute code and
// the reader FSM state encoding, so the NCO, reader and mixer agree.
package wavetable_reader_pkg;

   localparam int DIV        = 1024;
   localparam int ADDR_W     = 12;
   localparam int DATA_W     = 16;
   localparam int GAIN_W     = 8;
   localparam int ROM_LAT    = 1;
   localparam int UNITY_GAIN = 128;
   localparam int GAIN_SHIFT = $clog2(UNITY_GAIN);

   localparam logic [ADDR_W-1:0] MUTE_ADDR = 12'hC00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_SCALE,
      ST_OUT
   } state_t;

endpackage

// File: rtl/wavetable_reader_sample_scaler.sv
// Signed sample times unsigned gain (UNITY_GAIN = 1.0), floor-shifted back to
// sample scale and saturated to the signed DATA_W range. Purely combinational.
module wavetable_reader_sample_scaler
   import wavetable_reader_pkg::*;
(
   input  logic [DATA_W-1:0] data,
   input  logic [GAIN_W-1:0] gain,
   output logic [DATA_W-1:0] scaled
);

   localparam int PW = DATA_W + GAIN_W + 1;
   localparam logic signed [PW-1:0] MAX_V = PW'(2**(DATA_W-1) - 1);
   localparam logic signed [PW-1:0] MIN_V = PW'(-(2**(DATA_W-1)));

   logic signed [PW-1:0] d_ext;
   logic signed [PW-1:0] g_ext;
   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] shr;

   always_comb begin
      d_ext = PW'($signed(data));
      // gain is unsigned: zero-extend so 255 never reads as negative
      g_ext = PW'({1'b0, gain});
      prod  = d_ext * g_ext;
      shr   = prod >>> GAIN_SHIFT;
      if (shr > MAX_V)
         scaled = MAX_V[DATA_W-1:0];
      else if (shr < MIN_V)
         scaled = MIN_V[DATA_W-1:0];
      else
         scaled = shr[DATA_W-1:0];
   end

endmodule

// File: rtl/wavetable_reader.sv
// Wavetable reader: once per sample period fetch the table word at the NCO
// address, scale by the voice gain and hand it downstream over valid/ready.
module wavetable_reader
   import wavetable_reader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic [GAIN_W-1:0] gain,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_en,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] sample,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic              overrun,
   input  logic              clr_overrun
);

   localparam int CNT_W    = $clog2(DIV);
   localparam int WAIT_CYC = ROM_LAT - 1;
   localparam int WCNT_W   = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

   logic [CNT_W-1:0]  div_cnt;
   logic              tick;
   logic              drop;
   state_t            state;
   logic [GAIN_W-1:0] g_q;
   logic [WCNT_W-1:0] wait_cnt;
   logic [DATA_W-1:0] scaled;

   assign tick = (div_cnt == CNT_W'(DIV - 1));
   assign drop = tick && (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (!rst)
         div_cnt <= '0;
      else if (tick)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + CNT_W'(1);
   end

   // a drop in the same cycle as a clear must leave the flag set
   always_ff @(posedge clk) begin
      if (!rst)
         overrun <= 1'b0;
      else if (drop)
         overrun <= 1'b1;
      else if (clr_overrun)
         overrun <= 1'b0;
   end

   wavetable_reader_sample_scaler u_sample_scaler (
      .data   (rom_data),
      .gain   (g_q),
      .scaled (scaled)
   );

   // rom_addr doubles as the latched table address for the fetch
   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= ST_IDLE;
         rom_addr     <= '0;
         rom_en       <= 1'b0;
         g_q          <= '0;
         wait_cnt     <= '0;
         sample       <= '0;
         sample_valid <= 1'b0;
      end else begin
         rom_en <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (tick) begin
                  g_q <= gain;
                  if (addr == MUTE_ADDR) begin
                     sample       <= '0;
                     sample_valid <= 1'b1;
                     state        <= ST_OUT;
                  end else begin
                     rom_addr <= addr;
                     rom_en   <= 1'b1;
                     state    <= ST_FETCH;
                  end
               end
            end
            ST_FETCH: begin
               wait_cnt <= '0;
               state    <= (WAIT_CYC == 0) ? ST_SCALE : ST_WAIT;
            end
            ST_WAIT: begin
               wait_cnt <= wait_cnt + WCNT_W'(1);
               if (wait_cnt == WCNT_W'(WAIT_CYC - 1))
                  state <= ST_SCALE;
            end
            // rom_data is valid in this cycle and is consumed directly
            ST_SCALE: begin
               sample       <= scaled;
               sample_valid <= 1'b1;
               state        <= ST_OUT;
            end
            ST_OUT: begin
               if (sample_ready) begin
                  sample_valid <= 1'b0;
                  state        <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
